// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pseudo-random generator.
// Holds structure selectors, default primitive taps and the single-step next-state function.
package lfsr_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lfsr_fsm_e;

  // Maximal-length masks; Galois form is the same polynomial with the +1 term in bit 0.
  function automatic logic [31:0] default_taps(input int dw, input int mode);
    logic [31:0] fib;
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - dw);
    case (dw)
      3:       fib = 32'h0000_0006;
      4:       fib = 32'h0000_000C;
      5:       fib = 32'h0000_0014;
      6:       fib = 32'h0000_0030;
      7:       fib = 32'h0000_0060;
      8:       fib = 32'h0000_00B8;
      9:       fib = 32'h0000_0110;
      10:      fib = 32'h0000_0240;
      11:      fib = 32'h0000_0500;
      12:      fib = 32'h0000_0829;
      13:      fib = 32'h0000_100D;
      14:      fib = 32'h0000_2015;
      15:      fib = 32'h0000_6000;
      16:      fib = 32'h0000_D008;
      17:      fib = 32'h0001_2000;
      18:      fib = 32'h0002_0400;
      19:      fib = 32'h0004_0023;
      20:      fib = 32'h0009_0000;
      21:      fib = 32'h0014_0000;
      22:      fib = 32'h0030_0000;
      23:      fib = 32'h0042_0000;
      24:      fib = 32'h00E1_0000;
      25:      fib = 32'h0120_0000;
      26:      fib = 32'h0200_0023;
      27:      fib = 32'h0400_0013;
      28:      fib = 32'h0900_0000;
      29:      fib = 32'h1400_0000;
      30:      fib = 32'h2000_0029;
      31:      fib = 32'h4800_0000;
      32:      fib = 32'h8020_0003;
      default: fib = 32'h0000_0006;
    endcase
    if (mode == MODE_GAL) begin
      return ((fib << 1) | 32'h0000_0001) & mask;
    end else begin
      return fib & mask;
    end
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps,
                                            input int dw, input int mode);
    logic [31:0] mask;
    logic        msb;
    logic [31:0] nxt;
    mask = 32'hFFFF_FFFF >> (32 - dw);
    msb  = state[5'(dw - 1)];
    if (mode == MODE_GAL) begin
      nxt = (state << 1) ^ ({32{msb}} & taps);
    end else begin
      nxt = (state << 1) | {31'd0, ^(state & taps & mask)};
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_step_n.sv
// Combinational advance: STEPS single LFSR shifts chained within one cycle.
module lfsr_prng_step_n
  import lfsr_pkg::*;
#(
  parameter int              DW    = 6,
  parameter logic [DW-1:0]   TAPS  = 6'h30,
  parameter int              MODE  = 0,
  parameter int              STEPS = 1
) (
  input  logic [DW-1:0] state_i,
  output logic [DW-1:0] state_o
);

  logic [DW-1:0] chain_s [STEPS+1];

  assign chain_s[0] = state_i;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign chain_s[g+1] = DW'(lfsr_step(32'(chain_s[g]), 32'(TAPS), DW, MODE));
  end

  assign state_o = chain_s[STEPS];

endmodule

// File: rtl/lfsr_prng.sv
// Pseudo-random word generator with valid/ready output, seed load, zero-seed
// substitution and full-period wrap detection relative to the loaded seed.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int                 DW_LFSR    = 6,
  parameter logic [DW_LFSR-1:0] TAPS_LFSR  = 6'h30,
  parameter int                 MODE_LFSR  = 0,
  parameter int                 STEPS_LFSR = 1,
  parameter logic [DW_LFSR-1:0] SEED_LFSR  = 6'h01
) (
  input  logic               i_clk_lfsr,
  input  logic               i_rst_lfsr,
  input  logic               i_en_lfsr,
  input  logic               i_load_lfsr,
  input  logic [DW_LFSR-1:0] i_seed_lfsr,
  input  logic               i_ready_lfsr,
  output logic               o_valid_lfsr,
  output logic [DW_LFSR-1:0] o_rnd_lfsr,
  output logic [DW_LFSR-1:0] o_cnt_lfsr,
  output logic               o_wrap_lfsr,
  output logic               o_lockup_lfsr
);

  localparam logic [DW_LFSR-1:0] ZERO = {DW_LFSR{1'b0}};

  lfsr_fsm_e          fsm_q, fsm_d;
  logic [DW_LFSR-1:0] state_q, state_d;
  logic [DW_LFSR-1:0] seed_q, seed_d;
  logic [DW_LFSR-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               lockup_q, lockup_d;
  logic [DW_LFSR-1:0] adv_s;
  logic [DW_LFSR-1:0] ld_val_s;
  logic [DW_LFSR-1:0] next_s;
  logic               advance_s;

  lfsr_prng_step_n #(
    .DW    (DW_LFSR),
    .TAPS  (TAPS_LFSR),
    .MODE  (MODE_LFSR),
    .STEPS (STEPS_LFSR)
  ) u_step_n (
    .state_i (state_q),
    .state_o (adv_s)
  );

  assign ld_val_s = (i_seed_lfsr == ZERO) ? SEED_LFSR : i_seed_lfsr;

  // Next-state: load wins, otherwise the EMPTY/FULL handshake decides whether to advance.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    lockup_d  = 1'b0;
    advance_s = 1'b0;
    next_s    = adv_s;
    if (i_load_lfsr) begin
      state_d  = ld_val_s;
      seed_d   = ld_val_s;
      fsm_d    = ST_EMPTY;
      cnt_d    = ZERO;
      lockup_d = (i_seed_lfsr == ZERO);
    end else begin
      case (fsm_q)
        ST_EMPTY: begin
          if (i_en_lfsr) begin
            fsm_d = ST_FULL;
          end else begin
            fsm_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (i_ready_lfsr) begin
            if (i_en_lfsr) begin
              advance_s = 1'b1;
            end else begin
              fsm_d = ST_EMPTY;
            end
          end else begin
            fsm_d = ST_FULL;
          end
        end
        default: fsm_d = ST_EMPTY;
      endcase
      // A zero state can only come from a non-maximal mask; recover to the reset seed.
      if (advance_s) begin
        if (state_q == ZERO) begin
          next_s   = SEED_LFSR;
          lockup_d = 1'b1;
        end else begin
          next_s = adv_s;
        end
        state_d = next_s;
        if (next_s == seed_q) begin
          wrap_d = 1'b1;
          cnt_d  = ZERO;
        end else begin
          cnt_d = cnt_q + DW_LFSR'(1);
        end
      end else begin
        state_d = state_q;
      end
    end
  end

  // State, seed, counter and flag registers.
  always_ff @(posedge i_clk_lfsr or posedge i_rst_lfsr) begin
    if (i_rst_lfsr) begin
      fsm_q    <= ST_EMPTY;
      state_q  <= SEED_LFSR;
      seed_q   <= SEED_LFSR;
      cnt_q    <= ZERO;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign o_valid_lfsr  = (fsm_q == ST_FULL);
  assign o_rnd_lfsr    = state_q;
  assign o_cnt_lfsr    = cnt_q;
  assign o_wrap_lfsr   = wrap_q;
  assign o_lockup_lfsr = lockup_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed self-checking bench for lfsr_prng: four configurations share one stimulus stream.
module tb_lfsr_prng;

  logic       clk_s = 1'b0;
  logic       rst_s;
  logic       en_s;
  logic       load_s;
  logic [5:0] seed_s;
  logic       ready_s;

  logic       f_valid, g_valid, t_valid, d_valid;
  logic [5:0] f_rnd, f_cnt, g_rnd, g_cnt, t_rnd, t_cnt;
  logic [2:0] d_rnd, d_cnt;
  logic       f_wrap, g_wrap, t_wrap, d_wrap;
  logic       f_lock, g_lock, t_lock, d_lock;

  int checks = 0;
  int errors = 0;

  always #5 clk_s = ~clk_s;

  lfsr_prng #(.DW_LFSR(6), .TAPS_LFSR(6'h30), .MODE_LFSR(0), .STEPS_LFSR(1), .SEED_LFSR(6'h01)) u_fib (
    .i_clk_lfsr(clk_s), .i_rst_lfsr(rst_s), .i_en_lfsr(en_s), .i_load_lfsr(load_s),
    .i_seed_lfsr(seed_s), .i_ready_lfsr(ready_s), .o_valid_lfsr(f_valid), .o_rnd_lfsr(f_rnd),
    .o_cnt_lfsr(f_cnt), .o_wrap_lfsr(f_wrap), .o_lockup_lfsr(f_lock));

  lfsr_prng #(.DW_LFSR(6), .TAPS_LFSR(6'h21), .MODE_LFSR(1), .STEPS_LFSR(1), .SEED_LFSR(6'h01)) u_gal (
    .i_clk_lfsr(clk_s), .i_rst_lfsr(rst_s), .i_en_lfsr(en_s), .i_load_lfsr(load_s),
    .i_seed_lfsr(seed_s), .i_ready_lfsr(ready_s), .o_valid_lfsr(g_valid), .o_rnd_lfsr(g_rnd),
    .o_cnt_lfsr(g_cnt), .o_wrap_lfsr(g_wrap), .o_lockup_lfsr(g_lock));

  lfsr_prng #(.DW_LFSR(6), .TAPS_LFSR(6'h30), .MODE_LFSR(0), .STEPS_LFSR(3), .SEED_LFSR(6'h01)) u_fib3 (
    .i_clk_lfsr(clk_s), .i_rst_lfsr(rst_s), .i_en_lfsr(en_s), .i_load_lfsr(load_s),
    .i_seed_lfsr(seed_s), .i_ready_lfsr(ready_s), .o_valid_lfsr(t_valid), .o_rnd_lfsr(t_rnd),
    .o_cnt_lfsr(t_cnt), .o_wrap_lfsr(t_wrap), .o_lockup_lfsr(t_lock));

  // Zero feedback mask: the state drains to zero and must recover to the seed.
  lfsr_prng #(.DW_LFSR(3), .TAPS_LFSR(3'h0), .MODE_LFSR(0), .STEPS_LFSR(1), .SEED_LFSR(3'h1)) u_dw3 (
    .i_clk_lfsr(clk_s), .i_rst_lfsr(rst_s), .i_en_lfsr(en_s), .i_load_lfsr(load_s),
    .i_seed_lfsr(seed_s[2:0]), .i_ready_lfsr(ready_s), .o_valid_lfsr(d_valid), .o_rnd_lfsr(d_rnd),
    .o_cnt_lfsr(d_cnt), .o_wrap_lfsr(d_wrap), .o_lockup_lfsr(d_lock));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  function automatic logic [5:0] ref_fib6(input logic [5:0] s, input int n);
    logic [5:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = {v[4:0], v[5] ^ v[4]};
    end
    return v;
  endfunction

  logic [5:0]  exp_seq [6] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
  logic [5:0]  prev;
  logic [5:0]  expv;
  logic [63:0] seen;
  int          wrap_cnt;
  int          wrap_at;
  int          distinct;

  initial begin
    rst_s = 1'b1; en_s = 1'b0; load_s = 1'b0; seed_s = 6'h00; ready_s = 1'b1;
    tick(); tick();
    check_eq("rst_rnd", 32'(f_rnd), 32'h01);
    check_eq("rst_valid", 32'(f_valid), 32'h0);
    check_eq("rst_cnt", 32'(f_cnt), 32'h0);
    check_eq("rst_wrap", 32'(f_wrap), 32'h0);
    check_eq("rst_lock", 32'(f_lock), 32'h0);

    // Priming then free-running sequence
    rst_s = 1'b0; en_s = 1'b1;
    tick();
    check_eq("prime_valid", 32'(f_valid), 32'h1);
    check_eq("prime_rnd", 32'(f_rnd), 32'h01);
    check_eq("prime_cnt", 32'(f_cnt), 32'h0);
    check_eq("prime3_rnd", 32'(t_rnd), 32'h01);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("fib_seq", 32'(f_rnd), 32'(exp_seq[i]));
      check_eq("fib_cnt", 32'(f_cnt), i + 1);
      if (i == 0) check_eq("fib3_a1", 32'(t_rnd), 32'h08);
      if (i == 1) check_eq("fib3_a2", 32'(t_rnd), 32'h03);
      if (i == 1) check_eq("fib3_ref", 32'(t_rnd), 32'(ref_fib6(6'h01, 6)));
      if (i == 2) begin
        check_eq("zero_rnd", 32'(d_rnd), 32'h0);
        check_eq("zero_lock", 32'(d_lock), 32'h0);
        check_eq("zero_cnt", 32'(d_cnt), 32'h3);
      end
      if (i == 3) begin
        check_eq("recov_rnd", 32'(d_rnd), 32'h1);
        check_eq("recov_lock", 32'(d_lock), 32'h1);
        check_eq("recov_wrap", 32'(d_wrap), 32'h1);
        check_eq("recov_cnt", 32'(d_cnt), 32'h0);
      end
    end

    // Full period from loaded seed 01
    load_s = 1'b1; seed_s = 6'h01;
    tick();
    check_eq("ld_valid", 32'(f_valid), 32'h0);
    check_eq("ld_cnt", 32'(f_cnt), 32'h0);
    check_eq("ld_rnd", 32'(f_rnd), 32'h01);
    load_s = 1'b0;
    tick();
    check_eq("ld_prime", 32'(f_valid), 32'h1);
    prev = 6'h01; seen = 64'h2; wrap_cnt = 0; wrap_at = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      expv = ref_fib6(prev, 1);
      check_eq("period_rnd", 32'(f_rnd), 32'(expv));
      check_eq("period_wrap", 32'(f_wrap), (k == 63) ? 32'h1 : 32'h0);
      if (f_wrap) begin
        wrap_cnt++;
        wrap_at = k;
      end
      if (k < 63) seen[f_rnd] = 1'b1;
      prev = expv;
    end
    distinct = 0;
    for (int b = 0; b < 64; b++) distinct += int'(seen[b]);
    check_eq("wrap_count", 32'(wrap_cnt), 32'd1);
    check_eq("wrap_at", 32'(wrap_at), 32'd63);
    check_eq("wrap_cnt0", 32'(f_cnt), 32'h0);
    check_eq("distinct", 32'(distinct), 32'd63);
    check_eq("no_zero", 32'(seen[0]), 32'h0);

    // Galois from seed 20
    load_s = 1'b1; seed_s = 6'h20;
    tick();
    load_s = 1'b0;
    tick();
    check_eq("gal_prime", 32'(g_rnd), 32'h20);
    check_eq("gal_valid", 32'(g_valid), 32'h1);
    tick();
    check_eq("gal_a1", 32'(g_rnd), 32'h21);
    tick();
    check_eq("gal_a2", 32'(g_rnd), 32'h23);
    check_eq("gal_cnt", 32'(g_cnt), 32'h2);

    // Zero seed substitution
    load_s = 1'b1; seed_s = 6'h00;
    tick();
    check_eq("z_rnd", 32'(g_rnd), 32'h01);
    check_eq("z_valid", 32'(g_valid), 32'h0);
    check_eq("z_lock", 32'(g_lock), 32'h1);
    check_eq("z_cnt", 32'(g_cnt), 32'h0);
    load_s = 1'b0;
    tick();
    check_eq("z_lock_off", 32'(g_lock), 32'h0);
    check_eq("z_valid_on", 32'(g_valid), 32'h1);

    // Backpressure, load during stall, drop to EMPTY when disabled
    tick();
    check_eq("bp_pre", 32'(f_rnd), 32'h02);
    ready_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_s = i[0];
      tick();
      check_eq("bp_rnd", 32'(f_rnd), 32'h02);
      check_eq("bp_valid", 32'(f_valid), 32'h1);
    end
    load_s = 1'b1; seed_s = 6'h15; en_s = 1'b1;
    tick();
    check_eq("bp_ld_valid", 32'(f_valid), 32'h0);
    check_eq("bp_ld_rnd", 32'(f_rnd), 32'h15);
    load_s = 1'b0;
    tick();
    check_eq("bp_prime", 32'(f_valid), 32'h1);
    ready_s = 1'b1; en_s = 1'b0;
    tick();
    check_eq("dis_valid", 32'(f_valid), 32'h0);
    check_eq("dis_rnd", 32'(f_rnd), 32'h15);

    // Async reset mid-stream
    en_s = 1'b1;
    tick();
    tick();
    check_eq("pre_rst_rnd", 32'(f_rnd), 32'h2B);
    check_eq("pre_rst_cnt", 32'(f_cnt), 32'h1);
    #2 rst_s = 1'b1;
    #1;
    check_eq("arst_rnd", 32'(f_rnd), 32'h01);
    check_eq("arst_valid", 32'(f_valid), 32'h0);
    check_eq("arst_cnt", 32'(f_cnt), 32'h0);
    check_eq("arst_rnd3", 32'(t_rnd), 32'h01);
    check_eq("arst_grnd", 32'(g_rnd), 32'h01);
    #2 rst_s = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
